// File: rtl/pulse_gen_pkg.sv
// Shared encodings and time-of-day field layout for the multi-channel PPS pulse generator.
package pulse_gen_pkg;

  localparam int TIME_W    = 56;
  localparam int YEAR_LSB  = 40;
  localparam int MONTH_LSB = 32;
  localparam int DAY_LSB   = 24;
  localparam int HOUR_LSB  = 16;
  localparam int MIN_LSB   = 8;
  localparam int SEC_LSB   = 0;

  typedef enum logic [1:0] {
    G_IDLE     = 2'd0,
    G_WAIT_TOD = 2'd1,
    G_WAIT_PPS = 2'd2,
    G_RUN      = 2'd3
  } gstate_t;

  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_OFFSET = 2'd1,
    CH_RUN    = 2'd2,
    CH_DONE   = 2'd3
  } chstate_t;

  function automatic logic [TIME_W-1:0] pack_time(
    input logic [15:0] year,
    input logic [7:0]  month,
    input logic [7:0]  day,
    input logic [7:0]  hour,
    input logic [7:0]  minutes,
    input logic [7:0]  seconds
  );
    logic [TIME_W-1:0] t;
    t = '0;
    t[YEAR_LSB  +: 16] = year;
    t[MONTH_LSB +: 8]  = month;
    t[DAY_LSB   +: 8]  = day;
    t[HOUR_LSB  +: 8]  = hour;
    t[MIN_LSB   +: 8]  = minutes;
    t[SEC_LSB   +: 8]  = seconds;
    return t;
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: shadowed settings, OFF/OFFSET/RUN/DONE sequencing and the
// registered pulse output, all stepped by the shared microsecond tick.
module pulse_channel #(
  parameter int CNT_W  = 24,
  parameter int PCNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_start,
  input  logic              i_tick,
  input  logic [CNT_W-1:0]  i_width_high,
  input  logic [CNT_W-1:0]  i_width_period,
  input  logic [CNT_W-1:0]  i_phase_offset,
  input  logic [PCNT_W-1:0] i_pulse_count,
  output logic              o_pulse,
  output logic              o_running,
  output logic              o_done
);
  import pulse_gen_pkg::*;

  chstate_t          r_state;
  chstate_t          w_state_nxt;
  logic [CNT_W-1:0]  r_width;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_offset;
  logic [PCNT_W-1:0] r_count;
  logic [CNT_W-1:0]  r_micro;
  logic [CNT_W-1:0]  w_micro_nxt;
  logic [CNT_W-1:0]  r_off_cnt;
  logic [CNT_W-1:0]  w_off_nxt;
  logic [PCNT_W-1:0] r_pulse_num;
  logic [PCNT_W-1:0] w_pnum_nxt;
  logic [PCNT_W-1:0] w_pnum_inc;
  logic [CNT_W-1:0]  w_period_m1;
  logic [CNT_W-1:0]  w_offset_m1;
  logic              w_latch;
  logic              r_pulse;

  // Period and offset are only ever zero-checked before use, so these never underflow in use.
  assign w_period_m1 = r_period - 1'b1;
  assign w_offset_m1 = r_offset - 1'b1;
  assign w_pnum_inc  = r_pulse_num + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_micro_nxt = r_micro;
    w_off_nxt   = r_off_cnt;
    w_pnum_nxt  = r_pulse_num;
    w_latch     = 1'b0;
    if (!i_enable) begin
      w_state_nxt = CH_OFF;
      w_micro_nxt = '0;
      w_off_nxt   = '0;
      w_pnum_nxt  = '0;
    end else begin
      case (r_state)
        CH_OFF: begin
          if (i_start && (i_width_period != '0)) begin
            w_latch     = 1'b1;
            w_micro_nxt = '0;
            w_off_nxt   = '0;
            w_pnum_nxt  = '0;
            w_state_nxt = (i_phase_offset == '0) ? CH_RUN : CH_OFFSET;
          end
        end
        CH_OFFSET: begin
          if (i_tick) begin
            if (r_off_cnt == w_offset_m1) begin
              w_state_nxt = CH_RUN;
              w_micro_nxt = '0;
            end else begin
              w_off_nxt = r_off_cnt + 1'b1;
            end
          end
        end
        CH_RUN: begin
          if (i_tick) begin
            if (r_micro == w_period_m1) begin
              w_micro_nxt = '0;
              w_pnum_nxt  = w_pnum_inc;
              if ((r_count != '0) && (w_pnum_inc == r_count)) begin
                w_state_nxt = CH_DONE;
              end
            end else begin
              w_micro_nxt = r_micro + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= CH_OFF;
      r_width     <= '0;
      r_period    <= '0;
      r_offset    <= '0;
      r_count     <= '0;
      r_micro     <= '0;
      r_off_cnt   <= '0;
      r_pulse_num <= '0;
      r_pulse     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_micro     <= w_micro_nxt;
      r_off_cnt   <= w_off_nxt;
      r_pulse_num <= w_pnum_nxt;
      if (w_latch) begin
        r_width  <= i_width_high;
        r_period <= i_width_period;
        r_offset <= i_phase_offset;
        r_count  <= i_pulse_count;
      end
      // Gating with the live enable lets a dropped channel go low on the very next edge.
      r_pulse <= i_enable && (r_state == CH_RUN) && (r_micro < r_width);
    end
  end

  assign o_pulse   = r_pulse;
  assign o_running = (r_state == CH_OFFSET) || (r_state == CH_RUN);
  assign o_done    = (r_state == CH_DONE);

endmodule

// File: rtl/multi_pulse_generator.sv
// N-channel PPS-aligned pulse generator: arms on a Thunderbolt time-of-day match,
// starts all enabled channels on the next PPS rising edge, then free-runs.
module multi_pulse_generator #(
  parameter int N_CH          = 4,
  parameter int CLKS_PER_1_US = 10,
  parameter int CNT_W         = 24,
  parameter int PCNT_W        = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_pps_raw,
  input  logic [N_CH-1:0]          i_enable,
  input  logic [55:0]              i_arm_time,
  input  logic                     i_thunder_packet_dv,
  input  logic [55:0]              i_thunder_time,
  input  logic [N_CH*CNT_W-1:0]    i_width_high,
  input  logic [N_CH*CNT_W-1:0]    i_width_period,
  input  logic [N_CH*CNT_W-1:0]    i_phase_offset,
  input  logic [N_CH*PCNT_W-1:0]   i_pulse_count,
  output logic [N_CH-1:0]          o_pulse_out,
  output logic [N_CH-1:0]          o_ch_running,
  output logic [N_CH-1:0]          o_ch_done,
  output logic                     o_armed
);
  import pulse_gen_pkg::*;

  localparam int CLK_W = (CLKS_PER_1_US > 1) ? $clog2(CLKS_PER_1_US) : 1;
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_1_US - 1);

  logic       r_pps_s1;
  logic       r_pps_s2;
  logic       r_pps_hist;
  logic       r_pps_edge;
  gstate_t    r_gstate;
  gstate_t    w_gstate_nxt;
  logic [CLK_W-1:0] r_clk_cnt;
  logic       w_tick;
  logic       w_start;
  logic       w_any_en;
  logic       w_tod_match;
  logic [N_CH-1:0] w_pulse;
  logic [N_CH-1:0] w_running;
  logic [N_CH-1:0] w_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pps_s1   <= 1'b0;
      r_pps_s2   <= 1'b0;
      r_pps_hist <= 1'b0;
      r_pps_edge <= 1'b0;
    end else begin
      r_pps_s1   <= i_pps_raw;
      r_pps_s2   <= r_pps_s1;
      r_pps_hist <= r_pps_s2;
      r_pps_edge <= r_pps_s2 && !r_pps_hist;
    end
  end

  assign w_any_en    = |i_enable;
  assign w_tod_match = i_thunder_packet_dv && (i_thunder_time == i_arm_time);

  always_comb begin
    w_gstate_nxt = r_gstate;
    case (r_gstate)
      G_IDLE:     if (w_any_en)    w_gstate_nxt = G_WAIT_TOD;
      G_WAIT_TOD: if (w_tod_match) w_gstate_nxt = G_WAIT_PPS;
      G_WAIT_PPS: if (r_pps_edge)  w_gstate_nxt = G_RUN;
      default: ;
    endcase
    if (!w_any_en) w_gstate_nxt = G_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gstate <= G_IDLE;
    end else begin
      r_gstate <= w_gstate_nxt;
    end
  end

  assign w_start = (r_gstate == G_WAIT_PPS) && (w_gstate_nxt == G_RUN);
  assign w_tick  = (r_gstate == G_RUN) && (r_clk_cnt == CLK_LAST);

  // Held at zero outside RUN, so the tick phase is fixed by the start PPS alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_cnt <= '0;
    end else if ((r_gstate != G_RUN) || w_tick) begin
      r_clk_cnt <= '0;
    end else begin
      r_clk_cnt <= r_clk_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pulse_channel #(
      .CNT_W  (CNT_W),
      .PCNT_W (PCNT_W)
    ) u_ch (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_enable       (i_enable[c]),
      .i_start        (w_start),
      .i_tick         (w_tick),
      .i_width_high   (i_width_high[c*CNT_W +: CNT_W]),
      .i_width_period (i_width_period[c*CNT_W +: CNT_W]),
      .i_phase_offset (i_phase_offset[c*CNT_W +: CNT_W]),
      .i_pulse_count  (i_pulse_count[c*PCNT_W +: PCNT_W]),
      .o_pulse        (w_pulse[c]),
      .o_running      (w_running[c]),
      .o_done         (w_done[c])
    );
  end

  assign o_pulse_out  = w_pulse;
  assign o_ch_running = w_running;
  assign o_ch_done    = w_done;
  assign o_armed      = (r_gstate == G_WAIT_PPS) || (r_gstate == G_RUN);

endmodule
